rst_seq: RTL and testbench
==========================

// Module: rst_seq
// PURPOSE
//  - Power-good / reset sequencer sitting directly downstream of the tie/power-rail wrapper.
//  - Consumes the vdd_io / vdd_co rail indications (constant 1 in sim, real power-good on silicon).
//  - Produces staggered, glitch-free resets: IO domain released first, core domain STAGGER_CYCLES later.
//  - Supports a software-requested core-only reset.
// PARAMETERS
//  STAB_CYCLES     16    consecutive synced power-good cycles required before IO reset release (>=1)
//  STAGGER_CYCLES  4     cycles between IO release and core release; also sw-reset core hold length (>=1)
//  CNT_W           8     shared counter width; must satisfy 2**CNT_W > max(STAB_CYCLES, STAGGER_CYCLES)
//  WDT_CYCLES      1024  watchdog timeout in cycles; used only with RST_SEQ_WDT_EN
// PORTS
//  i_clk         in   1  single clock
//  i_rst         in   1  synchronous, active-high reset
//  i_vdd_io      in   1  IO rail good (async; from wrap_nettie vdd_io)
//  i_vdd_co      in   1  core rail good (async; from wrap_nettie vdd_co)
//  i_sw_rst      in   1  software core-reset request; sampled level, honoured only in RUN
//  i_wdt_kick    in   1  watchdog kick; ignored without RST_SEQ_WDT_EN
//  o_rst_io      out  1  IO-domain reset, active-high, registered
//  o_rst_core    out  1  core-domain reset, active-high, registered
//  o_ready       out  1  high only in RUN (== ~o_rst_core & ~o_rst_io)
//  o_wdt_fired   out  1  sticky watchdog-expired flag; constant 0 without RST_SEQ_WDT_EN
// BEHAVIOUR
//  - Reset (i_rst=1):
//    - state=WAIT_PWR, cnt=0, sync flops=0.
//    - o_rst_io=1, o_rst_core=1, o_ready=0, o_wdt_fired=0.
//  - Rail sync: pg = AND of both rails after a 2-flop synchronizer each. Latency is 2 edges.
//  - Outputs are registered and decoded from next_state, so they change on the edge that enters a state.
//  - States:
//    - WAIT_PWR: rst_io=1, rst_core=1. If pg=1, go to STAB with cnt=0.
//    - STAB: rst_io=1, rst_core=1.
//      - pg=0: go to WAIT_PWR (count discarded).
//      - cnt==STAB_CYCLES-1: go to REL_IO with cnt=0.
//      - Otherwise: cnt++.
//    - REL_IO: rst_io=0, rst_core=1. If cnt==STAGGER_CYCLES-1, go to RUN; otherwise cnt++.
//    - RUN: rst_io=0, rst_core=0, o_ready=1. If i_sw_rst=1 (or the watchdog expires), go to REL_IO with cnt=0.
//  - Power loss: pg=0 in any state moves to WAIT_PWR on that edge, asserting both resets.
//    - Power loss has priority over i_sw_rst and over the watchdog on the same edge.
//  - Timing: edge 1 is the first edge with i_rst sampled low; rails are high throughout.
//    - STAB entered at edge 3.
//    - o_rst_io falls at edge STAB_CYCLES+3.
//    - o_rst_core falls and o_ready rises at edge STAB_CYCLES+STAGGER_CYCLES+3.
//  - sw reset: held i_sw_rst re-triggers on each RUN entry. A pulse outside RUN is dropped (not queued).
//  - i_rst mid-sequence: returns to WAIT_PWR on that edge and the full sequence restarts.
//  - Counter never wraps: compare-then-clear at the terminal value; cnt is cleared on every state change.
// CONFIGURATION
//  - RST_SEQ_WDT_EN defined:
//    - wdt counter runs only in RUN and is cleared when i_wdt_kick=1 or outside RUN.
//    - At wdt==WDT_CYCLES-1 with no kick: same transition as sw reset, and o_wdt_fired<=1.
//    - o_wdt_fired is sticky until i_rst.
//  - RST_SEQ_WDT_EN undefined:
//    - No wdt logic; i_wdt_kick unused; o_wdt_fired tied 0.
//    - Port list is identical in both builds.
// STRUCTURE
//  - rst_seq_pkg holds:
//    - typedef enum logic [1:0] {WAIT_PWR, STAB, REL_IO, RUN} rst_seq_state_t
//    - default localparams for STAB/STAGGER/WDT cycles
//  - Sub-module sync_2ff (width param, sync-reset to 0), instanced once with width 2 for both rails.
//  - Single FSM + one shared CNT_W counter in rst_seq; wdt counter inside `ifdef RST_SEQ_WDT_EN.
// TESTING
//  1. Rails=1, release i_rst (defaults) -> rst_io falls at edge 19, rst_core falls / o_ready rises at edge 23.
//  2. i_vdd_co drops for 1 cycle during STAB (cnt=10) -> back to WAIT_PWR; rst_io falls 16+3 edges after rail returns.
//  3. In RUN pulse i_sw_rst 1 cycle -> o_rst_core=1, o_ready=0 for exactly 4 cycles; o_rst_io stays 0.
//  4. In RUN drop i_vdd_io with i_sw_rst=1 same cycle -> both resets assert 2 edges later (sync latency), state WAIT_PWR.
//  5. Assert i_rst while in REL_IO -> next edge rst_io=1, rst_core=1, o_ready=0; full 23-edge sequence repeats.
//  6. WDT_EN, WDT_CYCLES=8, no kick in RUN -> core reset at RUN edge 8, o_wdt_fired=1 sticky; with kicks every 5 cycles, never fires.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// ============================================================================
// Module   : rst_seq_pkg
// Purpose  : Shared state encoding and default timing constants for rst_seq.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_PWR = 2'd0,
        STAB     = 2'd1,
        REL_IO   = 2'd2,
        RUN      = 2'd3
    } rst_seq_state_t;

    localparam int unsigned c_def_stab_cycles    = 16;
    localparam int unsigned c_def_stagger_cycles = 4;
    localparam int unsigned c_def_cnt_w          = 8;
    localparam int unsigned c_def_wdt_cycles     = 1024;

endpackage

`default_nettype wire

// File: rtl/rst_seq_sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer, WIDTH bits, synchronously cleared to 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/rst_seq.sv
// ============================================================================
// Module   : rst_seq
// Purpose  : Power-good reset sequencer; IO reset released first, core later,
//            plus software core-only reset. Optional watchdog: RST_SEQ_WDT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int unsigned STAB_CYCLES    = c_def_stab_cycles,
    parameter int unsigned STAGGER_CYCLES = c_def_stagger_cycles,
    parameter int unsigned CNT_W          = c_def_cnt_w,
    parameter int unsigned WDT_CYCLES     = c_def_wdt_cycles
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_vdd_io,
    input  logic i_vdd_co,
    input  logic i_sw_rst,
    input  logic i_wdt_kick,
    output logic o_rst_io,
    output logic o_rst_core,
    output logic o_ready,
    output logic o_wdt_fired
);

    localparam logic [CNT_W-1:0] c_stab_last    = CNT_W'(STAB_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_stagger_last = CNT_W'(STAGGER_CYCLES - 1);

    logic [1:0]       w_rails_sync;
    logic             w_pg;
    logic             w_wdt_expire;
    rst_seq_state_t   r_state;
    rst_seq_state_t   w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_next_cnt;
    logic             r_rst_io;
    logic             r_rst_core;
    logic             r_ready;

    sync_2ff #(
        .WIDTH (2)
    ) u_rail_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   ({i_vdd_io, i_vdd_co}),
        .o_q   (w_rails_sync)
    );

    assign w_pg = &w_rails_sync;

    // Power loss is checked first in every state so it outranks sw/wdt resets.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            WAIT_PWR: begin
                w_next_cnt = '0;
                if (w_pg) w_next_state = STAB;
            end
            STAB: begin
                if (!w_pg) begin
                    w_next_state = WAIT_PWR;
                    w_next_cnt   = '0;
                end else if (r_cnt == c_stab_last) begin
                    w_next_state = REL_IO;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            REL_IO: begin
                if (!w_pg) begin
                    w_next_state = WAIT_PWR;
                    w_next_cnt   = '0;
                end else if (r_cnt == c_stagger_last) begin
                    w_next_state = RUN;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt + 1'b1;
                end
            end
            RUN: begin
                w_next_cnt = '0;
                if (!w_pg) begin
                    w_next_state = WAIT_PWR;
                end else if (i_sw_rst || w_wdt_expire) begin
                    w_next_state = REL_IO;
                end
            end
            default: begin
                w_next_state = WAIT_PWR;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they move on the edge that enters it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= WAIT_PWR;
            r_cnt      <= '0;
            r_rst_io   <= 1'b1;
            r_rst_core <= 1'b1;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_rst_io   <= (w_next_state == WAIT_PWR) || (w_next_state == STAB);
            r_rst_core <= (w_next_state != RUN);
            r_ready    <= (w_next_state == RUN);
        end
    end

    assign o_rst_io   = r_rst_io;
    assign o_rst_core = r_rst_core;
    assign o_ready    = r_ready;

`ifdef RST_SEQ_WDT_EN
    localparam int unsigned      c_wdt_w    = $clog2(WDT_CYCLES + 1);
    localparam logic [c_wdt_w-1:0] c_wdt_last = c_wdt_w'(WDT_CYCLES - 1);

    logic [c_wdt_w-1:0] r_wdt;
    logic               r_wdt_fired;

    assign w_wdt_expire = (r_state == RUN) && !i_wdt_kick && (r_wdt == c_wdt_last);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wdt       <= '0;
            r_wdt_fired <= 1'b0;
        end else begin
            if ((r_state != RUN) || i_wdt_kick || w_wdt_expire) r_wdt <= '0;
            else                                               r_wdt <= r_wdt + 1'b1;
            if (w_wdt_expire && w_pg) r_wdt_fired <= 1'b1;
        end
    end

    assign o_wdt_fired = r_wdt_fired;
`else
    localparam int unsigned c_unused_wdt_cycles = WDT_CYCLES;
    logic w_unused_kick;

    assign w_unused_kick = i_wdt_kick;
    assign w_wdt_expire  = 1'b0;
    assign o_wdt_fired   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rst_seq.sv
// ============================================================================
// Module   : tb_rst_seq
// Purpose  : Self-checking bench for rst_seq: directed scenarios then random
//            traffic against a hold-timer reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rst_seq;

    localparam int STAB    = 16;
    localparam int STAGGER = 4;
    localparam int WDT     = 8;

    logic clk = 1'b0;
    logic rst, vdd_io, vdd_co, sw_rst, wdt_kick;
    logic o_rst_io, o_rst_core, o_ready, o_wdt_fired;

    int n_cmp = 0;
    int n_err = 0;
    int edge_n = 0;

    // Reference model state: rail delay line, good-streak length, core hold timer.
    logic h1 = 1'b0, h2 = 1'b0;
    int   up = 0, left = 0, wdog = 0;
    logic e_io = 1'b1, e_core = 1'b1, e_fired = 1'b0;

    always #5 clk = ~clk;

    rst_seq #(
        .STAB_CYCLES    (STAB),
        .STAGGER_CYCLES (STAGGER),
        .CNT_W          (8),
        .WDT_CYCLES     (WDT)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_vdd_io    (vdd_io),
        .i_vdd_co    (vdd_co),
        .i_sw_rst    (sw_rst),
        .i_wdt_kick  (wdt_kick),
        .o_rst_io    (o_rst_io),
        .o_rst_core  (o_rst_core),
        .o_ready     (o_ready),
        .o_wdt_fired (o_wdt_fired)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    task automatic tick();
        logic pg, was_run, fire;
        @(posedge clk);
        pg      = h2;
        h2      = rst ? 1'b0 : h1;
        h1      = rst ? 1'b0 : (vdd_io & vdd_co);
        was_run = !e_io && !e_core;
        fire    = 1'b0;
        if (rst) begin
            up = 0; wdog = 0; e_io = 1'b1; e_core = 1'b1; e_fired = 1'b0;
        end else if (!pg) begin
            up = 0; wdog = 0; e_io = 1'b1; e_core = 1'b1;
        end else begin
            if (up < STAB + 2) up++;
`ifdef RST_SEQ_WDT_EN
            if (!was_run || wdt_kick) wdog = 0;
            else if (wdog == WDT - 1) begin fire = 1'b1; wdog = 0; end
            else wdog++;
`endif
            if (up <= STAB) begin
                e_io = 1'b1; e_core = 1'b1;
            end else if (up == STAB + 1) begin
                e_io = 1'b0; e_core = 1'b1; left = STAGGER - 1;
            end else if (was_run && (sw_rst || fire)) begin
                e_core = 1'b1; left = STAGGER - 1;
                if (fire) e_fired = 1'b1;
            end else if (left > 0) begin
                left--; e_core = 1'b1;
            end else begin
                e_core = 1'b0;
            end
        end
        edge_n = rst ? 0 : edge_n + 1;
        #1;
        chk("rst_io",    o_rst_io,    e_io);
        chk("rst_core",  o_rst_core,  e_core);
        chk("ready",     o_ready,     !e_io && !e_core);
        chk("wdt_fired", o_wdt_fired, e_fired);
    endtask

    // Ticks until the chosen reset output reaches val; reports edge or -1 on timeout.
    task automatic wait_for(input bit core, input logic val, output int at);
        at = -1;
        for (int k = 0; k < 200; k++) begin
            tick();
            if ((core ? o_rst_core : o_rst_io) == val) begin
                at = edge_n;
                break;
            end
        end
    endtask

    initial begin
        int at, n;
        rst = 1'b1; vdd_io = 1'b1; vdd_co = 1'b1; sw_rst = 1'b0; wdt_kick = 1'b0;
        repeat (3) tick();
        chk("reset_io", o_rst_io, 1);
        chk("reset_core", o_rst_core, 1);
        chk("reset_ready", o_ready, 0);

        // Power-up sequence from reset release
        rst = 1'b0;
        wait_for(1'b0, 1'b0, at);
        chk("io_release_edge", at, STAB + 3);
        wait_for(1'b1, 1'b0, at);
        chk("core_release_edge", at, STAB + STAGGER + 3);
        chk("ready_in_run", o_ready, 1);

        // One-cycle software reset pulse in RUN
        repeat (2) tick();
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        chk("sw_core_assert", o_rst_core, 1);
        n = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (o_rst_core) n++;
            else break;
            chk("sw_io_held_low", o_rst_io, 0);
        end
        chk("sw_hold_len", n, STAGGER);

        // Power loss together with sw reset: IO reset follows after sync latency
        repeat (2) tick();
        vdd_io = 1'b0; sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        tick();
        chk("pwr_loss_io_e1", o_rst_io, 0);
        tick();
        chk("pwr_loss_io_e2", o_rst_io, 1);
        chk("pwr_loss_core_e2", o_rst_core, 1);
        vdd_io = 1'b1;

        // Core rail glitch during STAB restarts the stabilisation count
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (13) tick();
        vdd_co = 1'b0;
        tick();
        vdd_co = 1'b1;
        wait_for(1'b0, 1'b0, at);
        chk("glitch_io_release_edge", at, 33);

        // i_rst while in REL_IO restarts the whole sequence
        tick();
        rst = 1'b1;
        tick();
        chk("midrst_io", o_rst_io, 1);
        chk("midrst_core", o_rst_core, 1);
        chk("midrst_ready", o_ready, 0);
        rst = 1'b0;
        wait_for(1'b0, 1'b0, at);
        chk("re_io_release_edge", at, STAB + 3);
        wait_for(1'b1, 1'b0, at);
        chk("re_core_release_edge", at, STAB + STAGGER + 3);

`ifdef RST_SEQ_WDT_EN
        n = 0;
        for (int k = 0; k < 50; k++) begin
            tick();
            n++;
            if (o_rst_core) break;
        end
        chk("wdt_fire_run_edge", n, WDT);
        chk("wdt_fired_flag", o_wdt_fired, 1);
        wait_for(1'b1, 1'b0, at);
        for (int k = 0; k < 60; k++) begin
            wdt_kick = (k % 5 == 0);
            tick();
            chk("wdt_kicked_core", o_rst_core, 0);
        end
        wdt_kick = 1'b0;
        chk("wdt_fired_sticky", o_wdt_fired, 1);
`endif

        // Random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            rst      = ($urandom_range(0, 199) == 0);
            vdd_io   = ($urandom_range(0, 59) != 0);
            vdd_co   = ($urandom_range(0, 59) != 0);
            sw_rst   = ($urandom_range(0, 24) == 0);
            wdt_kick = ($urandom_range(0, 2) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
